// File: rtl/ctrl_fanout_merger.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fanout_merger
// Purpose  : Fans root control messages out to child links (broadcast/unicast)
//            and round-robin merges child replies into one upstream stream.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_fanout_merger #(
   parameter int CTRL_FIFO_WIDTH = 64,
   parameter int NUM_CHILDREN    = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [CTRL_FIFO_WIDTH-1:0]            down_data,
   input  logic                                  down_valid,
   output logic                                  down_ready,
   output logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] child_data,
   output logic [NUM_CHILDREN-1:0]               child_valid,
   input  logic [NUM_CHILDREN-1:0]               child_ready,
   input  logic [NUM_CHILDREN*CTRL_FIFO_WIDTH-1:0] child_rx_data,
   input  logic [NUM_CHILDREN-1:0]               child_rx_valid,
   output logic [NUM_CHILDREN-1:0]               child_rx_ready,
   output logic [CTRL_FIFO_WIDTH-1:0]            up_data,
   output logic                                  up_valid,
   input  logic                                  up_ready,
   output logic [15:0]                           drop_count,
   output logic                                  busy
);

   localparam int c_PTR_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

   // Downstream holding register
   logic                       r_hold_valid;
   logic [CTRL_FIFO_WIDTH-1:0] r_hold_data;
   logic [NUM_CHILDREN-1:0]    r_pending;
   logic [15:0]                r_drop_count;

   logic [7:0]              w_dest;
   logic                    w_bcast;
   logic                    w_ucast;
   logic                    w_accept;
   logic [NUM_CHILDREN-1:0] w_onehot;
   logic [NUM_CHILDREN-1:0] w_pending_next;

   // Upstream slots and output register
   logic [NUM_CHILDREN-1:0]    r_slot_valid;
   logic [CTRL_FIFO_WIDTH-1:0] r_slot_data [NUM_CHILDREN];
   logic                       r_up_valid;
   logic [CTRL_FIFO_WIDTH-1:0] r_up_data;
   logic [c_PTR_W-1:0]         r_rr_ptr;

   logic               w_grant_found;
   logic [c_PTR_W-1:0] w_grant;
   logic [c_PTR_W-1:0] w_rr_next;
   logic               w_load_up;

   assign w_dest   = down_data[CTRL_FIFO_WIDTH-1 -: 8];
   assign w_bcast  = (w_dest == 8'hFF);
   assign w_ucast  = (int'(w_dest) < NUM_CHILDREN);
   assign w_accept = down_valid && !r_hold_valid;

   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
         w_onehot[i] = (w_dest == 8'(i));
      end
   end

   assign w_pending_next = r_pending & ~(child_valid & child_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_pending    <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_accept && (w_bcast || w_ucast)) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= down_data;
            r_pending    <= w_bcast ? {NUM_CHILDREN{1'b1}} : w_onehot;
         end else if (r_hold_valid) begin
            // Hold frees in the same edge the last outstanding child accepts
            r_pending    <= w_pending_next;
            r_hold_valid <= |w_pending_next;
         end
         if (w_accept && !w_bcast && !w_ucast && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
      end
   end

   // Round-robin search starting at r_rr_ptr
   always_comb begin : p_grant
      int                 j;
      logic [c_PTR_W-1:0] idx;
      j             = 0;
      idx           = '0;
      w_grant_found = 1'b0;
      w_grant       = '0;
      for (int k = 0; k < NUM_CHILDREN; k++) begin
         j = int'(r_rr_ptr) + k;
         if (j >= NUM_CHILDREN) begin
            j = j - NUM_CHILDREN;
         end
         idx = c_PTR_W'(j);
         if (!w_grant_found && r_slot_valid[idx]) begin
            w_grant_found = 1'b1;
            w_grant       = idx;
         end
      end
   end

   assign w_rr_next = (w_grant == c_PTR_W'(NUM_CHILDREN - 1)) ? '0 : w_grant + c_PTR_W'(1);
   assign w_load_up = (!r_up_valid || up_ready) && w_grant_found;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot_valid <= '0;
         for (int i = 0; i < NUM_CHILDREN; i++) begin
            r_slot_data[i] <= '0;
         end
         r_up_valid <= 1'b0;
         r_up_data  <= '0;
         r_rr_ptr   <= '0;
      end else begin
         for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (w_load_up && (w_grant == c_PTR_W'(i))) begin
               r_slot_valid[i] <= 1'b0;
            end else if (child_rx_valid[i] && !r_slot_valid[i]) begin
               r_slot_valid[i] <= 1'b1;
               r_slot_data[i]  <= child_rx_data[i*CTRL_FIFO_WIDTH +: CTRL_FIFO_WIDTH];
            end
         end
         if (w_load_up) begin
            r_up_valid <= 1'b1;
            r_up_data  <= r_slot_data[w_grant];
            r_rr_ptr   <= w_rr_next;
         end else if (up_ready) begin
            r_up_valid <= 1'b0;
         end
      end
   end

   assign down_ready     = !r_hold_valid;
   assign child_valid    = {NUM_CHILDREN{r_hold_valid}} & r_pending;
   assign child_data     = {NUM_CHILDREN{r_hold_data}};
   assign child_rx_ready = ~r_slot_valid;
   assign up_data        = r_up_data;
   assign up_valid       = r_up_valid;
   assign drop_count     = r_drop_count;
   assign busy           = r_hold_valid | (|r_slot_valid) | r_up_valid;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fanout_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_fanout_merger
// Purpose  : Directed self-checking bench for ctrl_fanout_merger (N=4, W=64).
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_fanout_merger;

   localparam int c_W = 64;
   localparam int c_N = 4;

   logic               clk;
   logic               reset;
   logic [c_W-1:0]     down_data;
   logic               down_valid;
   logic               down_ready;
   logic [c_N*c_W-1:0] child_data;
   logic [c_N-1:0]     child_valid;
   logic [c_N-1:0]     child_ready;
   logic [c_N*c_W-1:0] child_rx_data;
   logic [c_N-1:0]     child_rx_valid;
   logic [c_N-1:0]     child_rx_ready;
   logic [c_W-1:0]     up_data;
   logic               up_valid;
   logic               up_ready;
   logic [15:0]        drop_count;
   logic               busy;

   int checks = 0;
   int errors = 0;

   ctrl_fanout_merger #(.CTRL_FIFO_WIDTH(c_W), .NUM_CHILDREN(c_N)) dut (
      .clk(clk), .reset(reset),
      .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
      .child_data(child_data), .child_valid(child_valid), .child_ready(child_ready),
      .child_rx_data(child_rx_data), .child_rx_valid(child_rx_valid),
      .child_rx_ready(child_rx_ready),
      .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
      .drop_count(drop_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [63:0] reply(input int child, input int burst);
      return {8'hE0, 8'h05, 32'h0000_0000, 8'(burst), 8'(child)};
   endfunction

   task automatic push_replies(input logic [c_N-1:0] mask, input int burst);
      for (int i = 0; i < c_N; i++) begin
         child_rx_data[i*c_W +: c_W] = reply(i, burst);
      end
      child_rx_valid = mask;
   endtask

   // Four simultaneous replies with up_ready=1: expect 0,1,2,3 back to back
   task automatic burst_in_order(input int burst);
      push_replies(4'hF, burst);
      up_ready = 1'b1;
      tick();
      child_rx_valid = '0;
      check("rr_slots_full", 64'(child_rx_ready), 64'h0);
      check("rr_latency", 64'(up_valid), 64'h0);
      for (int i = 0; i < c_N; i++) begin
         tick();
         check("rr_valid", 64'(up_valid), 64'h1);
         check("rr_order", up_data, reply(i, burst));
      end
      tick();
      check("rr_drained", 64'(up_valid), 64'h0);
      check("rr_idle", 64'(busy), 64'h0);
   endtask

   logic [63:0] msg;

   initial begin
      reset          = 1'b1;
      down_data      = '0;
      down_valid     = 1'b0;
      child_ready    = '0;
      child_rx_data  = '0;
      child_rx_valid = '0;
      up_ready       = 1'b0;
      tick();
      tick();
      check("rst_down_ready", 64'(down_ready), 64'h1);
      check("rst_child_valid", 64'(child_valid), 64'h0);
      check("rst_rx_ready", 64'(child_rx_ready), 64'hF);
      check("rst_up_valid", 64'(up_valid), 64'h0);
      check("rst_up_data", up_data, 64'h0);
      check("rst_drop", 64'(drop_count), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      reset = 1'b0;
      tick();

      // Broadcast MOVE_TO_STAGE, all children ready
      msg         = {8'hFF, 8'h00, 8'h03, 40'h00_1234_5678};
      down_data   = msg;
      down_valid  = 1'b1;
      child_ready = 4'hF;
      tick();
      down_valid = 1'b0;
      check("bc_valid", 64'(child_valid), 64'hF);
      check("bc_down_ready", 64'(down_ready), 64'h0);
      check("bc_busy", 64'(busy), 64'h1);
      for (int i = 0; i < c_N; i++) begin
         check("bc_data", child_data[i*c_W +: c_W], msg);
      end
      tick();
      check("bc_valid_end", 64'(child_valid), 64'h0);
      check("bc_down_ready_end", 64'(down_ready), 64'h1);

      // Broadcast with child 2 stalled for 5 cycles
      msg         = {8'hFF, 8'h00, 8'h03, 40'h00_0000_0002};
      down_data   = msg;
      down_valid  = 1'b1;
      child_ready = 4'b1011;
      tick();
      down_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         check("st_valid", 64'(child_valid), (k == 1) ? 64'hF : 64'h4);
         check("st_down_ready", 64'(down_ready), 64'h0);
         check("st_data2", child_data[2*c_W +: c_W], msg);
         if (k == 6) child_ready = 4'hF;
         if (k < 6) tick();
      end
      tick();
      check("st_valid_end", 64'(child_valid), 64'h0);
      check("st_down_ready_end", 64'(down_ready), 64'h1);

      // Unicast to child 1, then an out-of-range dest that must be dropped
      msg        = {8'h01, 8'h00, 8'h07, 40'h00_0000_0011};
      down_data  = msg;
      down_valid = 1'b1;
      tick();
      down_valid = 1'b0;
      check("uc_valid", 64'(child_valid), 64'h2);
      check("uc_data", child_data[1*c_W +: c_W], msg);
      tick();
      check("uc_valid_end", 64'(child_valid), 64'h0);
      check("uc_down_ready", 64'(down_ready), 64'h1);
      down_data  = {8'h09, 8'h00, 8'h07, 40'h00_0000_0099};
      down_valid = 1'b1;
      tick();
      down_valid = 1'b0;
      check("drop_valid", 64'(child_valid), 64'h0);
      check("drop_down_ready", 64'(down_ready), 64'h1);
      check("drop_count", 64'(drop_count), 64'h1);
      check("drop_busy", 64'(busy), 64'h0);
      tick();
      check("drop_valid2", 64'(child_valid), 64'h0);

      // Round-robin merge, twice
      burst_in_order(1);
      burst_in_order(2);

      // Back-pressure: up_ready low for 10 cycles with 4 replies queued
      push_replies(4'hF, 3);
      up_ready = 1'b0;
      tick();
      child_rx_valid = '0;
      for (int k = 2; k <= 11; k++) begin
         tick();
         check("bp_valid", 64'(up_valid), 64'h1);
         check("bp_data", up_data, reply(0, 3));
         check("bp_rx_ready", 64'(child_rx_ready), 64'h1);
      end
      up_ready = 1'b1;
      for (int i = 1; i < c_N; i++) begin
         tick();
         check("bp_rel_valid", 64'(up_valid), 64'h1);
         check("bp_rel_data", up_data, reply(i, 3));
      end
      tick();
      check("bp_drained", 64'(up_valid), 64'h0);
      check("bp_rx_ready_end", 64'(child_rx_ready), 64'hF);

      // Reset mid-operation: child 3 pending, slots 0 and 1 full
      down_data   = {8'h03, 8'h00, 8'h07, 40'h00_0000_0033};
      down_valid  = 1'b1;
      child_ready = 4'b0111;
      push_replies(4'b0011, 4);
      up_ready    = 1'b0;
      tick();
      down_valid     = 1'b0;
      child_rx_valid = '0;
      check("mr_pending", 64'(child_valid), 64'h8);
      check("mr_slots", 64'(child_rx_ready), 64'hC);
      reset = 1'b1;
      tick();
      check("mr_child_valid", 64'(child_valid), 64'h0);
      check("mr_up_valid", 64'(up_valid), 64'h0);
      check("mr_busy", 64'(busy), 64'h0);
      check("mr_down_ready", 64'(down_ready), 64'h1);
      check("mr_rx_ready", 64'(child_rx_ready), 64'hF);
      check("mr_drop", 64'(drop_count), 64'h0);
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
